tt_um_restoring_divider4: RTL

TT_UM_RESTORING_DIVIDER4 -- requirements
Module: tt_um_restoring_divider4

---
 rtl/tt_um_restoring_divider4.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/tt_um_restoring_divider4.sv
`default_nettype none
// ============================================================================
//  Module   : tt_um_restoring_divider4
//  Purpose  : 4-bit unsigned restoring divider. One restoring step per clock
//             (MSB first, 5-bit partial remainder), with a registered
//             quotient/remainder and a divide-by-zero flag.
//  Ports    : clk      - clock, rising edge
//             rst      - asynchronous active-high reset
//             ui_in    - [3:0] dividend N, [7:4] divisor D
//             uio_in   - [0] start request, [7:1] ignored
//             uo_out   - [3:0] quotient Q, [7:4] remainder R (registered)
//             uio_out  - [7] done, [6] busy, [5] div0, [4:0] zero
//             uio_oe   - constant 8'b1110_0000
//             ena      - ignored
//  Options  : DIV_EARLY_EXIT_EN - when defined, N<D (D!=0) completes at the
//             capture edge with Q=0, R=N instead of running four steps.
//  Revision : 1.0 - initial release
// ============================================================================
module tt_um_restoring_divider4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    localparam logic [7:0] c_UIO_OE    = 8'b1110_0000;
    localparam logic [1:0] c_LAST_STEP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [3:0] r_dividend;
    logic [3:0] r_divisor;
    logic [4:0] r_prem;
    logic [3:0] r_qacc;
    logic [1:0] r_count;
    logic [3:0] r_quot;
    logic [3:0] r_rem;
    logic       r_div0;

    logic       w_start;
    logic [3:0] w_n;
    logic [3:0] w_d;
    logic       w_d_zero;
    logic       w_fast;
    logic       w_done;
    logic       w_busy;
    logic [4:0] w_shift;
    logic [5:0] w_diff;
    logic       w_ge;
    logic [4:0] w_prem_next;
    logic [3:0] w_q_next;
    logic       w_unused;

    assign w_start  = uio_in[0];
    assign w_n      = ui_in[3:0];
    assign w_d      = ui_in[7:4];
    assign w_d_zero = (w_d == 4'd0);
    assign w_unused = &{1'b0, ena, uio_in[7:1]};

`ifdef DIV_EARLY_EXIT_EN
    // Quotient is trivially zero when the dividend is below the divisor.
    assign w_fast = !w_d_zero && (w_n < w_d);
`else
    assign w_fast = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, trial-subtract D.
    // The extra MSB of w_diff is the borrow, i.e. "result negative".
    assign w_shift     = {r_prem[3:0], r_dividend[3]};
    assign w_diff      = {1'b0, w_shift} - {2'b00, r_divisor};
    assign w_ge        = ~w_diff[5];
    assign w_prem_next = w_ge ? w_diff[4:0] : w_shift;
    assign w_q_next    = {r_qacc[2:0], w_ge};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    if (w_d_zero || w_fast) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = CALC;
                    end
                end
            end
            CALC: begin
                w_busy = 1'b1;
                if (r_count == c_LAST_STEP) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dividend <= 4'd0;
            r_divisor  <= 4'd0;
            r_prem     <= 5'd0;
            r_qacc     <= 4'd0;
            r_count    <= 2'd0;
            r_quot     <= 4'd0;
            r_rem      <= 4'd0;
            r_div0     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_dividend <= w_n;
                        r_divisor  <= w_d;
                        r_prem     <= 5'd0;
                        r_qacc     <= 4'd0;
                        r_count    <= 2'd0;
                        // Short-circuit outcomes are written straight to the
                        // result registers since DONE is entered next.
                        if (w_d_zero) begin
                            r_quot <= 4'hF;
                            r_rem  <= w_n;
                            r_div0 <= 1'b1;
                        end else if (w_fast) begin
                            r_quot <= 4'd0;
                            r_rem  <= w_n;
                            r_div0 <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_prem     <= w_prem_next;
                    r_qacc     <= w_q_next;
                    r_dividend <= {r_dividend[2:0], 1'b0};
                    r_count    <= r_count + 2'd1;
                    if (r_count == c_LAST_STEP) begin
                        r_quot <= w_q_next;
                        r_rem  <= w_prem_next[3:0];
                        r_div0 <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign uo_out  = {r_rem, r_quot};
    assign uio_out = {w_done, w_busy, r_div0, 5'b00000};
    assign uio_oe  = c_UIO_OE;

endmodule
`default_nettype wire
